// File: rtl/supernova_pkg.sv
// Shared ROB sizing, field widths and the per-entry record.
package supernova_pkg;

    localparam int FETCH_WIDTH    = 2;
    localparam int REG_WIDTH      = 32;
    localparam int GPR_TAG_WIDTH  = 6;
    localparam int ARCH_RD_WIDTH  = 5;
    localparam int ROB_ENTRIES    = 32;
    localparam int ROB_IDX_WIDTH  = $clog2(ROB_ENTRIES);
    localparam int COMMIT_WIDTH   = 2;

    // Exception bits live outside this record so they vanish entirely
    // when the exception feature is compiled out.
    typedef struct packed {
        logic                     valid;
        logic                     done;
        logic [REG_WIDTH-1:0]     pc;
        logic [ARCH_RD_WIDTH-1:0] arch_rd;
        logic [GPR_TAG_WIDTH-1:0] phys_tag;
        logic [REG_WIDTH-1:0]     data;
    } rob_entry_t;

endpackage

// File: rtl/supernova_rob_commit_sel.sv
// Commit-lane selection over the head window of the ROB.
// A lane retires only if every older lane in the window retires too; a
// faulted entry may only retire alone, in lane 0.
module supernova_rob_commit_sel #(
    parameter int COMMIT_WIDTH = 2,
    parameter bit EXC_EN       = 1'b0
) (
    input  logic                    flush,
    input  logic [COMMIT_WIDTH-1:0] win_valid,
    input  logic [COMMIT_WIDTH-1:0] win_done,
    input  logic [COMMIT_WIDTH-1:0] win_exc,
    output logic [COMMIT_WIDTH-1:0] commit_valid,
    output logic                    commit_exc
);

    logic [COMMIT_WIDTH-1:0] exc_m;
    logic                    run;
    logic                    ok;
    logic                    prev_exc;

    // Prefix-AND of retire eligibility, broken by any fault past lane 0
    always_comb begin
        exc_m        = EXC_EN ? win_exc : '0;
        commit_valid = '0;
        commit_exc   = 1'b0;
        run          = !flush;
        prev_exc     = 1'b0;
        ok           = 1'b0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            ok = win_valid[k] & win_done[k] & !prev_exc;
            if (k > 0) ok = ok & !exc_m[k];
            run             = run & ok;
            commit_valid[k] = run;
            prev_exc        = exc_m[k];
        end
        commit_exc = commit_valid[0] & exc_m[0];
    end

endmodule

// File: rtl/supernova_rob.sv
// Reorder buffer: circular entry array with wrap-bit head/tail pointers,
// multi-lane allocate, multi-port writeback, in-order multi-lane retire.
// Optional feature macro: SUPERNOVA_ROB_EXCEPTION_EN (per-entry fault bits
// and faulted-entry retire on lane 0).
module supernova_rob
    import supernova_pkg::*;
#(
    parameter int ALLOC_WIDTH  = FETCH_WIDTH,
    parameter int WB_PORTS     = 2,
    parameter int COMMIT_WIDTH = supernova_pkg::COMMIT_WIDTH
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       redirect_valid_in,
    input  logic [ALLOC_WIDTH-1:0]                     alloc_valid_in,
    input  logic [ALLOC_WIDTH-1:0][REG_WIDTH-1:0]      alloc_pc_in,
    input  logic [ALLOC_WIDTH-1:0][ARCH_RD_WIDTH-1:0]  alloc_arch_rd_in,
    input  logic [ALLOC_WIDTH-1:0][GPR_TAG_WIDTH-1:0]  alloc_phys_tag_in,
    output logic                                       alloc_ready_out,
    output logic [ALLOC_WIDTH-1:0][ROB_IDX_WIDTH-1:0]  alloc_idx_out,
    input  logic [WB_PORTS-1:0]                        rob_wb_valid_in,
    input  logic [WB_PORTS-1:0][ROB_IDX_WIDTH-1:0]     rob_wb_idx_in,
    input  logic [WB_PORTS-1:0][REG_WIDTH-1:0]         rob_wb_data_in,
    input  logic [WB_PORTS-1:0]                        rob_wb_exception_in,
    output logic [COMMIT_WIDTH-1:0]                    commit_valid_out,
    output logic [COMMIT_WIDTH-1:0][REG_WIDTH-1:0]     commit_pc_out,
    output logic [COMMIT_WIDTH-1:0][ARCH_RD_WIDTH-1:0] commit_arch_rd_out,
    output logic [COMMIT_WIDTH-1:0][GPR_TAG_WIDTH-1:0] commit_phys_tag_out,
    output logic [COMMIT_WIDTH-1:0][REG_WIDTH-1:0]     commit_data_out,
    output logic                                       commit_exception_out,
    output logic                                       rob_empty_out
);

`ifdef SUPERNOVA_ROB_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
    logic [ROB_ENTRIES-1:0] exc_q;
`else
    localparam bit EXC_EN = 1'b0;
    logic unused_exc_in;
    assign unused_exc_in = ^rob_wb_exception_in;
`endif

    rob_entry_t                                rob_q [ROB_ENTRIES];
    logic [ROB_IDX_WIDTH:0]                    head_q, tail_q, count;
    logic [ROB_IDX_WIDTH:0]                    alloc_n, commit_n;
    logic [COMMIT_WIDTH-1:0][ROB_IDX_WIDTH-1:0] win_idx;
    logic [COMMIT_WIDTH-1:0]                   win_valid, win_done, win_exc;
    logic [COMMIT_WIDTH-1:0]                   commit_valid;
    logic                                      commit_exc;

    // Occupancy, free-space check (pre-commit count) and per-lane alloc slot
    always_comb begin
        count           = tail_q - head_q;
        alloc_ready_out = (ROB_ENTRIES - int'(count)) >= ALLOC_WIDTH;
        rob_empty_out   = (count == '0);
        alloc_n         = '0;
        alloc_idx_out   = '0;
        for (int i = 0; i < ALLOC_WIDTH; i++) begin
            alloc_idx_out[i] = tail_q[ROB_IDX_WIDTH-1:0] + ROB_IDX_WIDTH'(i);
            alloc_n          = alloc_n + (ROB_IDX_WIDTH+1)'(alloc_valid_in[i]);
        end
    end

    // Head window read-out feeding lane selection and the commit payload
    always_comb begin
        win_idx             = '0;
        win_valid           = '0;
        win_done            = '0;
        win_exc             = '0;
        commit_pc_out       = '0;
        commit_arch_rd_out  = '0;
        commit_phys_tag_out = '0;
        commit_data_out     = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++) begin
            win_idx[k]             = head_q[ROB_IDX_WIDTH-1:0] + ROB_IDX_WIDTH'(k);
            win_valid[k]           = rob_q[win_idx[k]].valid;
            win_done[k]            = rob_q[win_idx[k]].done;
`ifdef SUPERNOVA_ROB_EXCEPTION_EN
            win_exc[k]             = exc_q[win_idx[k]];
`endif
            commit_pc_out[k]       = rob_q[win_idx[k]].pc;
            commit_arch_rd_out[k]  = rob_q[win_idx[k]].arch_rd;
            commit_phys_tag_out[k] = rob_q[win_idx[k]].phys_tag;
            commit_data_out[k]     = rob_q[win_idx[k]].data;
        end
    end

    supernova_rob_commit_sel #(
        .COMMIT_WIDTH (COMMIT_WIDTH),
        .EXC_EN       (EXC_EN)
    ) u_commit_sel (
        .flush        (redirect_valid_in),
        .win_valid    (win_valid),
        .win_done     (win_done),
        .win_exc      (win_exc),
        .commit_valid (commit_valid),
        .commit_exc   (commit_exc)
    );

    // Retired lane count for head advance
    always_comb begin
        commit_n = '0;
        for (int k = 0; k < COMMIT_WIDTH; k++)
            commit_n = commit_n + (ROB_IDX_WIDTH+1)'(commit_valid[k]);
        commit_valid_out     = commit_valid;
        commit_exception_out = EXC_EN & commit_exc;
    end

    // Entry and pointer update: flush/reset dominates; otherwise writeback,
    // then retire clears, then allocation (disjoint slots from retire).
    always_ff @(posedge clk) begin
        if (rst || redirect_valid_in) begin
            head_q <= '0;
            tail_q <= '0;
            for (int e = 0; e < ROB_ENTRIES; e++) begin
                rob_q[e].valid <= 1'b0;
                rob_q[e].done  <= 1'b0;
            end
        end else begin
            // Later ports override earlier ones on the same index
            for (int p = 0; p < WB_PORTS; p++) begin
                if (rob_wb_valid_in[p] && rob_q[rob_wb_idx_in[p]].valid) begin
                    rob_q[rob_wb_idx_in[p]].done <= 1'b1;
                    rob_q[rob_wb_idx_in[p]].data <= rob_wb_data_in[p];
`ifdef SUPERNOVA_ROB_EXCEPTION_EN
                    exc_q[rob_wb_idx_in[p]]      <= rob_wb_exception_in[p];
`endif
                end
            end
            for (int k = 0; k < COMMIT_WIDTH; k++)
                if (commit_valid[k]) rob_q[win_idx[k]].valid <= 1'b0;
            if (alloc_ready_out) begin
                for (int i = 0; i < ALLOC_WIDTH; i++) begin
                    if (alloc_valid_in[i]) begin
                        rob_q[alloc_idx_out[i]].valid    <= 1'b1;
                        rob_q[alloc_idx_out[i]].done     <= 1'b0;
                        rob_q[alloc_idx_out[i]].pc       <= alloc_pc_in[i];
                        rob_q[alloc_idx_out[i]].arch_rd  <= alloc_arch_rd_in[i];
                        rob_q[alloc_idx_out[i]].phys_tag <= alloc_phys_tag_in[i];
`ifdef SUPERNOVA_ROB_EXCEPTION_EN
                        exc_q[alloc_idx_out[i]]          <= 1'b0;
`endif
                    end
                end
                tail_q <= tail_q + alloc_n;
            end
            head_q <= head_q + commit_n;
        end
    end

endmodule

// File: tb/tb_supernova_rob.sv
// Randomized + directed bench for supernova_rob against a queue-based
// in-order model of the ROB contents.
module tb_supernova_rob;

`ifdef SUPERNOVA_ROB_EXCEPTION_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              redirect_valid_in;
    logic [1:0]        alloc_valid_in;
    logic [1:0][31:0]  alloc_pc_in;
    logic [1:0][4:0]   alloc_arch_rd_in;
    logic [1:0][5:0]   alloc_phys_tag_in;
    logic              alloc_ready_out;
    logic [1:0][4:0]   alloc_idx_out;
    logic [1:0]        rob_wb_valid_in;
    logic [1:0][4:0]   rob_wb_idx_in;
    logic [1:0][31:0]  rob_wb_data_in;
    logic [1:0]        rob_wb_exception_in;
    logic [1:0]        commit_valid_out;
    logic [1:0][31:0]  commit_pc_out;
    logic [1:0][4:0]   commit_arch_rd_out;
    logic [1:0][5:0]   commit_phys_tag_out;
    logic [1:0][31:0]  commit_data_out;
    logic              commit_exception_out;
    logic              rob_empty_out;

    supernova_rob dut (
        .clk                  (clk),
        .rst                  (rst),
        .redirect_valid_in    (redirect_valid_in),
        .alloc_valid_in       (alloc_valid_in),
        .alloc_pc_in          (alloc_pc_in),
        .alloc_arch_rd_in     (alloc_arch_rd_in),
        .alloc_phys_tag_in    (alloc_phys_tag_in),
        .alloc_ready_out      (alloc_ready_out),
        .alloc_idx_out        (alloc_idx_out),
        .rob_wb_valid_in      (rob_wb_valid_in),
        .rob_wb_idx_in        (rob_wb_idx_in),
        .rob_wb_data_in       (rob_wb_data_in),
        .rob_wb_exception_in  (rob_wb_exception_in),
        .commit_valid_out     (commit_valid_out),
        .commit_pc_out        (commit_pc_out),
        .commit_arch_rd_out   (commit_arch_rd_out),
        .commit_phys_tag_out  (commit_phys_tag_out),
        .commit_data_out      (commit_data_out),
        .commit_exception_out (commit_exception_out),
        .rob_empty_out        (rob_empty_out)
    );

    always #5 clk = ~clk;

    // Model: program-order queue of in-flight instructions plus head slot
    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [5:0]  tag;
        logic [31:0] data;
        bit          done;
        bit          exc;
    } ment_t;

    ment_t mq[$];
    int    mhead = 0;
    int    n_cmp = 0;
    int    n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic clr();
        rst                 = 1'b0;
        redirect_valid_in   = 1'b0;
        alloc_valid_in      = '0;
        alloc_pc_in         = '0;
        alloc_arch_rd_in    = '0;
        alloc_phys_tag_in   = '0;
        rob_wb_valid_in     = '0;
        rob_wb_idx_in       = '0;
        rob_wb_data_in      = '0;
        rob_wb_exception_in = '0;
    endtask

    task automatic set_alloc(input int lane, input logic [4:0] rd);
        alloc_valid_in[lane]    = 1'b1;
        alloc_pc_in[lane]       = $urandom;
        alloc_arch_rd_in[lane]  = rd;
        alloc_phys_tag_in[lane] = 6'($urandom);
    endtask

    task automatic set_wb(input int p, input int idx, input bit exc);
        rob_wb_valid_in[p]     = 1'b1;
        rob_wb_idx_in[p]       = 5'(idx);
        rob_wb_data_in[p]      = $urandom;
        rob_wb_exception_in[p] = exc;
    endtask

    // Compare outputs with the model for the inputs now applied, advance
    // the model across the coming edge, then move to the next falling edge.
    task automatic step();
        int       cnt, n, j;
        bit       ex, rdy;
        ment_t    e;
        #1;
        cnt = mq.size();
        rdy = (32 - cnt) >= 2;
        n   = 0;
        ex  = 1'b0;
        if (!redirect_valid_in) begin
            for (int k = 0; k < 2; k++) begin
                if (k >= cnt || !mq[k].done) break;
                if (mq[k].exc) begin
                    if (k == 0) begin n = 1; ex = 1'b1; end
                    break;
                end
                n++;
            end
        end
        if (!rst) begin
            chk("ready", alloc_ready_out, rdy);
            chk("empty", rob_empty_out, cnt == 0);
            for (int i = 0; i < 2; i++)
                chk("alloc_idx", alloc_idx_out[i], (mhead + cnt + i) % 32);
            chk("commit_valid", commit_valid_out, (1 << n) - 1);
            chk("commit_exc", commit_exception_out, ex);
            for (int k = 0; k < n; k++) begin
                chk("commit_pc", commit_pc_out[k], mq[k].pc);
                chk("commit_rd", commit_arch_rd_out[k], mq[k].rd);
                chk("commit_tag", commit_phys_tag_out[k], mq[k].tag);
                chk("commit_data", commit_data_out[k], mq[k].data);
            end
        end
        if (rst || redirect_valid_in) begin
            mq.delete();
            mhead = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rob_wb_valid_in[p]) begin
                    j = (int'(rob_wb_idx_in[p]) - mhead + 32) % 32;
                    if (j < cnt) begin
                        e      = mq[j];
                        e.done = 1'b1;
                        e.data = rob_wb_data_in[p];
                        e.exc  = EXC_EN && rob_wb_exception_in[p];
                        mq[j]  = e;
                    end
                end
            end
            repeat (n) void'(mq.pop_front());
            mhead = (mhead + n) % 32;
            if (rdy) begin
                for (int i = 0; i < 2; i++) begin
                    if (alloc_valid_in[i]) begin
                        e.pc   = alloc_pc_in[i];
                        e.rd   = alloc_arch_rd_in[i];
                        e.tag  = alloc_phys_tag_in[i];
                        e.data = '0;
                        e.done = 1'b0;
                        e.exc  = 1'b0;
                        mq.push_back(e);
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        step();
        step();
        clr();
    endtask

    initial begin
        int nl;
        clr();
        rst = 1'b1;
        @(negedge clk);
        do_reset();

        // Reset state
        #1;
        chk("rst_ready", alloc_ready_out, 1'b1);
        chk("rst_empty", rob_empty_out, 1'b1);
        chk("rst_cvalid", commit_valid_out, 2'b00);
        chk("rst_cexc", commit_exception_out, 1'b0);

        // Two allocations, both written back, retire together
        set_alloc(0, 5'd5); set_alloc(1, 5'd6); step();
        clr(); set_wb(0, 0, 0); set_wb(1, 1, 0); step();
        clr(); #1;
        chk("pair_cvalid", commit_valid_out, 2'b11);
        chk("pair_rd0", commit_arch_rd_out[0], 5'd5);
        chk("pair_rd1", commit_arch_rd_out[1], 5'd6);
        step();
        chk("pair_empty", rob_empty_out, 1'b1);
        chk("pair_tail", alloc_idx_out[0], 5'd2);

        // Fill to capacity, overflow request ignored, drain frees space
        do_reset();
        repeat (16) begin set_alloc(0, 5'd1); set_alloc(1, 5'd2); step(); end
        clr(); #1;
        chk("full_ready32", alloc_ready_out, 1'b0);
        set_alloc(0, 5'd3); set_alloc(1, 5'd4); step();
        clr(); set_wb(0, 0, 0); step();
        clr(); step();
        #1;
        chk("full_ready31", alloc_ready_out, 1'b0);
        chk("full_tail", alloc_idx_out[0], 5'd0);
        set_wb(0, 1, 0); set_wb(1, 2, 0); step();
        clr(); step();
        #1;
        chk("full_ready29", alloc_ready_out, 1'b1);

        // Out-of-order writeback holds retirement until the head is done
        do_reset();
        set_alloc(0, 5'd7); set_alloc(1, 5'd8); step();
        clr(); set_wb(0, 1, 0); step();
        clr(); #1;
        chk("ooo_hold", commit_valid_out, 2'b00);
        set_wb(1, 0, 0); step();
        clr(); #1;
        chk("ooo_both", commit_valid_out, 2'b11);
        step();

        // Faulted head retires alone on lane 0
        do_reset();
        set_alloc(0, 5'd9); set_alloc(1, 5'd10); step();
        clr(); set_wb(0, 0, 1); set_wb(1, 1, 0); step();
        clr(); #1;
        chk("exc_cvalid", commit_valid_out, EXC_EN ? 2'b01 : 2'b11);
        chk("exc_flag", commit_exception_out, EXC_EN);
        step();
        chk("exc_next", commit_valid_out, EXC_EN ? 2'b01 : 2'b00);
        chk("exc_next_flag", commit_exception_out, 1'b0);
        step();

        // Redirect with 10 live entries plus same-cycle alloc/writeback
        do_reset();
        repeat (5) begin set_alloc(0, 5'd11); set_alloc(1, 5'd12); step(); end
        clr(); set_wb(0, 0, 0); set_wb(1, 1, 0); step();
        clr();
        redirect_valid_in = 1'b1;
        set_alloc(0, 5'd13); set_alloc(1, 5'd14); set_wb(0, 2, 0); set_wb(1, 3, 0);
        #1;
        chk("redir_cvalid", commit_valid_out, 2'b00);
        step();
        clr(); #1;
        chk("redir_empty", rob_empty_out, 1'b1);
        chk("redir_tail", alloc_idx_out[0], 5'd0);

        // Random traffic
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            clr();
            nl = $urandom_range(0, 2);
            for (int i = 0; i < nl; i++) set_alloc(i, 5'($urandom));
            for (int p = 0; p < 2; p++) begin
                if ($urandom_range(0, 2) != 0) begin
                    if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                        set_wb(p, (mhead + $urandom_range(0, mq.size() - 1)) % 32,
                               $urandom_range(0, 7) == 0);
                    else
                        set_wb(p, $urandom_range(0, 31), $urandom_range(0, 7) == 0);
                end
            end
            redirect_valid_in = ($urandom_range(0, 59) == 0);
            rst               = ($urandom_range(0, 499) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/supernova_rob.md
SUPERNOVA_ROB -- requirements
Module: supernova_rob

Interface
REQ-001 SHALL have parameter ALLOC_WIDTH, default supernova_pkg::FETCH_WIDTH (2), allocation lanes per cycle.
REQ-002 SHALL have parameter WB_PORTS, default 2, writeback ports, one per ALU unit.
REQ-003 SHALL have parameter COMMIT_WIDTH, default 2, in-order retire lanes per cycle.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port redirect_valid_in, input, 1, pipeline flush.
REQ-007 SHALL have port alloc_valid_in, input, ALLOC_WIDTH, per-lane allocate request.
REQ-008 SHALL have port alloc_pc_in, input, ALLOC_WIDTH x REG_WIDTH, instruction PC.
REQ-009 SHALL have port alloc_arch_rd_in, input, ALLOC_WIDTH x 5, architectural destination; 0 means none.
REQ-010 SHALL have port alloc_phys_tag_in, input, ALLOC_WIDTH x GPR_TAG_WIDTH, renamed destination tag.
REQ-011 SHALL have port alloc_ready_out, output, 1, room for ALLOC_WIDTH entries.
REQ-012 SHALL have port alloc_idx_out, output, ALLOC_WIDTH x ROB_IDX_WIDTH, index assigned per lane (tail+i).
REQ-013 SHALL have port rob_wb_valid_in, input, WB_PORTS, writeback strobe.
REQ-014 SHALL have port rob_wb_idx_in, input, WB_PORTS x ROB_IDX_WIDTH, target entry.
REQ-015 SHALL have port rob_wb_data_in, input, WB_PORTS x REG_WIDTH, result value.
REQ-016 SHALL have port rob_wb_exception_in, input, WB_PORTS, result faulted.
REQ-017 SHALL have port commit_valid_out, output, COMMIT_WIDTH, retire lane valid.
REQ-018 SHALL have ports commit_pc_out, commit_arch_rd_out, commit_phys_tag_out, commit_data_out, output, COMMIT_WIDTH x field width, retired entry payload.
REQ-019 SHALL have port commit_exception_out, output, 1, lane-0 entry retires with fault.
REQ-020 SHALL have port rob_empty_out, output, 1, no valid entries.

Function
REQ-021 SHALL be a circular buffer of ROB_ENTRIES with head/tail pointers carrying one extra wrap bit; count = tail - head.
REQ-022 SHALL drive alloc_ready_out = (ROB_ENTRIES - count >= ALLOC_WIDTH), using pre-commit count.
REQ-023 SHALL require contiguous alloc_valid_in from lane 0; when alloc_ready_out, write lane i to tail+i and advance tail by popcount next edge; when not ready, ignore requests.
REQ-024 SHALL, on rob_wb_valid_in[p] for a valid entry, set done, store data and exception next edge; writeback to invalid entry ignored; same-index conflict: higher p wins.
REQ-025 SHALL drive commit combinationally from registered state: lane k valid iff entries head..head+k all valid and done and none of head..head+k-1 faulted.
REQ-026 SHALL retire a faulted entry only in lane 0, with commit_exception_out=1 and all other lanes 0.
REQ-027 SHALL advance head by number of valid commit lanes and clear those entries' valid bits next edge; pointers wrap modulo ROB_ENTRIES.
REQ-028 SHALL support alloc, writeback and commit in the same cycle; writeback latency to earliest commit is 1 cycle.
REQ-029 SHALL, on redirect_valid_in, force commit_valid_out=0 that cycle and clear all entries, head=tail=0 next edge; redirect overrides alloc, writeback, commit.

Reset
REQ-030 SHALL, with rst high at an edge, clear all valid/done bits, head=tail=0, regardless of operation in flight.
REQ-031 SHALL, after reset, output commit_valid_out=0, commit_exception_out=0, alloc_ready_out=1, rob_empty_out=1.

Configuration
REQ-032 SHALL, with SUPERNOVA_ROB_EXCEPTION_EN defined, store and act on rob_wb_exception_in per REQ-024..026.
REQ-033 SHALL, without SUPERNOVA_ROB_EXCEPTION_EN, ignore rob_wb_exception_in, tie commit_exception_out to 0, store no exception bits.

Structure
REQ-034 SHALL take rob_entry_t, ROB_ENTRIES (32), ROB_IDX_WIDTH, COMMIT_WIDTH from supernova_pkg.
REQ-035 SHALL place commit-lane selection in combinational sub-module supernova_rob_commit_sel.

Verification
REQ-036 SHALL test: after reset, alloc 2 lanes (rd 5, 6), writeback both -> next cycle commit_valid_out=2'b11, head=2.
REQ-037 SHALL test: alloc 32 entries -> alloc_ready_out=0 at count 31 and 32; extra alloc ignored; commit 2 -> ready=1.
REQ-038 SHALL test: writeback entry 1 before entry 0 -> no commit; then entry 0 done -> both retire same cycle.
REQ-039 SHALL test: entry 0 faulted, entry 1 done -> lane 0 only, commit_exception_out=1; entry 1 retires next cycle.
REQ-040 SHALL test: redirect with 10 entries and simultaneous alloc/writeback -> commit_valid_out=0, rob_empty_out=1 next cycle.
